// File: rtl/sio_host_sched.sv
// Host-side frame scheduler: round-robin grant of the one-command-per-frame link
// slot, plus tag tracking that routes each returned read word to its owner.
module sio_host_sched #(
  parameter int NREQ = 4,
  parameter int RLAT = 2
) (
  input  logic              c,
  input  logic              r,
  input  logic              link_up,
  input  logic              frame_start,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [80*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [79:0]       link_wdata,
  output logic              link_wvalid,
  input  logic              link_rvalid,
  input  logic [31:0]       link_rdata,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_data,
  output logic [31:0]       status
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_ready_q, req_ready_d;
  logic [79:0]           link_wdata_q, link_wdata_d;
  logic                  link_wvalid_q, link_wvalid_d;
  logic [NREQ-1:0]       resp_valid_q, resp_valid_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic [RLAT-1:0]       tag_valid_q, tag_valid_d;
  logic [RLAT-1:0][2:0]  tag_id_q, tag_id_d;
  logic                  consumed_q, consumed_d;
  logic [2:0]            last_grant_q, last_grant_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [15:0]           issued_q, issued_d;

  logic [IW-1:0] rot;
  logic          found;
  logic [2:0]    gnt_idx;
  logic [79:0]   grant_data;
  logic          grant_en;
  logic          hit;
  logic          miss;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    rot        = '0;
    found      = 1'b0;
    gnt_idx    = last_grant_q;
    grant_data = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rot = IW'((int'(last_grant_q) + k) % NREQ);
      if (!found && req_valid[rot]) begin
        found   = 1'b1;
        gnt_idx = 3'(rot);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (found && (gnt_idx == 3'(i))) grant_data = req_data[i*80 +: 80];
    end
  end

  assign grant_en = frame_start && link_up && found;
  // A response landing in the same cycle as frame_start uses the pre-shift last stage.
  assign hit  = link_rvalid && link_up && tag_valid_q[RLAT-1] && !consumed_q;
  assign miss = frame_start && link_up && tag_valid_q[RLAT-1] && !consumed_q && !hit;

  always_comb begin
    req_ready_d   = '0;
    link_wvalid_d = frame_start;
    link_wdata_d  = link_wdata_q;
    last_grant_d  = last_grant_q;
    issued_d      = issued_q;
    resp_valid_d  = '0;
    resp_data_d   = resp_data_q;
    tag_valid_d   = tag_valid_q;
    tag_id_d      = tag_id_q;
    consumed_d    = consumed_q;
    err_count_d   = err_count_q;

    if (frame_start) link_wdata_d = grant_en ? grant_data : 80'h0;
    if (grant_en) begin
      for (int i = 0; i < NREQ; i++) req_ready_d[i] = (gnt_idx == 3'(i));
      last_grant_d = gnt_idx;
      issued_d     = issued_q + 16'd1;
    end

    if (link_rvalid) resp_data_d = link_rdata;
    if (hit) begin
      for (int i = 0; i < NREQ; i++) resp_valid_d[i] = (tag_id_q[RLAT-1] == 3'(i));
    end

    if (miss && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;

    // Link down drops every in-flight tag silently; nothing is counted as missed.
    if (!link_up) begin
      tag_valid_d = '0;
      consumed_d  = 1'b1;
    end else if (frame_start) begin
      tag_valid_d[0] = grant_en;
      tag_id_d[0]    = gnt_idx;
      for (int k = 1; k < RLAT; k++) begin
        tag_valid_d[k] = tag_valid_q[k-1];
        tag_id_d[k]    = tag_id_q[k-1];
      end
      consumed_d = ~tag_valid_d[RLAT-1];
    end else if (hit) begin
      consumed_d = 1'b1;
    end
  end

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      req_ready_q   <= '0;
      link_wdata_q  <= '0;
      link_wvalid_q <= 1'b0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      tag_valid_q   <= '0;
      tag_id_q      <= '0;
      consumed_q    <= 1'b1;
      last_grant_q  <= 3'(NREQ - 1);
      err_count_q   <= '0;
      issued_q      <= '0;
    end else begin
      req_ready_q   <= req_ready_d;
      link_wdata_q  <= link_wdata_d;
      link_wvalid_q <= link_wvalid_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      tag_valid_q   <= tag_valid_d;
      tag_id_q      <= tag_id_d;
      consumed_q    <= consumed_d;
      last_grant_q  <= last_grant_d;
      err_count_q   <= err_count_d;
      issued_q      <= issued_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign link_wdata  = link_wdata_q;
  assign link_wvalid = link_wvalid_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign status      = {err_count_q, 5'b0, last_grant_q, issued_q};

endmodule
